// File: rtl/spi_cmd_parser_pkg.sv
// Shared SPI command parser definitions: command codes, fill bytes and
// the parser state encoding.
package spi_cmd_parser_pkg;

  localparam logic [7:0] CMD_WR  = 8'h80;
  localparam logic [7:0] CMD_RD  = 8'h81;
  localparam logic [7:0] TX_FILL = 8'hFF;
  localparam logic [7:0] TX_IDLE = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_H  = 4'd1,
    ST_ADDR_L  = 4'd2,
    ST_DATA_H  = 4'd3,
    ST_DATA_L  = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_RD_H    = 4'd6,
    ST_RD_L    = 4'd7,
    ST_DISCARD = 4'd8
  } state_t;

  // A state that is part of an unfinished frame (abort/resync is counted).
  function automatic logic in_frame(input state_t s);
    return (s != ST_IDLE) && (s != ST_DISCARD);
  endfunction

endpackage

// File: rtl/spi_cmd_parser.sv
// SPI command parser: turns received bytes into register write/read strobes
// and feeds read data back to the MISO shifter.
//
// Handshakes: all strobes (i_rx_valid, i_rd_valid, o_wr_en, o_rd_en,
// o_tx_load) are single-cycle, no backpressure. A strobe is consumed on the
// rising clk edge where it is high; associated data must be valid in that
// same cycle, and the parser's outputs are registered so data outputs are
// stable in every cycle their strobe is high.
module spi_cmd_parser
  import spi_cmd_parser_pkg::*;
#(
  parameter int ADDR_WD    = 16,
  parameter int DATA_WD    = 16,
  parameter int RD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_frame_active,
  input  logic               i_rx_valid,
  input  logic [8:0]         iv_rx_data,
  output logic               o_wr_en,
  output logic               o_rd_en,
  output logic [ADDR_WD-1:0] ov_addr,
  output logic [DATA_WD-1:0] ov_wr_data,
  input  logic               i_rd_valid,
  input  logic [DATA_WD-1:0] iv_rd_data,
  output logic [7:0]         ov_tx_data,
  output logic               o_tx_load,
  output logic [7:0]         ov_err_cnt,
  output state_t             dbg_state
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               is_rd_q, is_rd_d;
  logic               fa_q;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [DATA_WD-1:0] rd_q, rd_d;
  logic [ADDR_WD-1:0] addr_d;
  logic [DATA_WD-1:0] wdata_d;
  logic [7:0]         tx_d;
  logic               wr_d, rd_en_d, load_d, err_inc;
  logic               cmd_strobe, frame_fall;

  assign cmd_strobe = i_rx_valid & iv_rx_data[8];
  assign frame_fall = fa_q & ~i_frame_active;
  assign dbg_state  = state_q;

  // State and all registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_rd_q    <= 1'b0;
      fa_q       <= 1'b0;
      tcnt_q     <= '0;
      rd_q       <= '0;
      ov_addr    <= '0;
      ov_wr_data <= '0;
      ov_tx_data <= TX_IDLE;
      o_wr_en    <= 1'b0;
      o_rd_en    <= 1'b0;
      o_tx_load  <= 1'b0;
      ov_err_cnt <= '0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      fa_q       <= i_frame_active;
      tcnt_q     <= tcnt_d;
      rd_q       <= rd_d;
      ov_addr    <= addr_d;
      ov_wr_data <= wdata_d;
      ov_tx_data <= tx_d;
      o_wr_en    <= wr_d;
      o_rd_en    <= rd_en_d;
      o_tx_load  <= load_d;
      if (err_inc && (ov_err_cnt != 8'hFF)) ov_err_cnt <= ov_err_cnt + 8'd1;
    end
  end

  // Next state: command resync beats frame abort, which beats normal parsing
  // (including the read timeout).
  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    tcnt_d  = tcnt_q;
    rd_d    = rd_q;
    addr_d  = ov_addr;
    wdata_d = ov_wr_data;
    tx_d    = ov_tx_data;
    wr_d    = 1'b0;
    rd_en_d = 1'b0;
    load_d  = 1'b0;
    err_inc = 1'b0;
    if (cmd_strobe) begin
      if (in_frame(state_q)) err_inc = 1'b1;
      tx_d   = TX_IDLE;
      tcnt_d = '0;
      if (iv_rx_data[7:0] == CMD_WR) begin
        is_rd_d = 1'b0;
        state_d = ST_ADDR_H;
      end else if (iv_rx_data[7:0] == CMD_RD) begin
        is_rd_d = 1'b1;
        state_d = ST_ADDR_H;
      end else begin
        err_inc = 1'b1;
        state_d = ST_DISCARD;
      end
    end else if (frame_fall && in_frame(state_q)) begin
      err_inc = 1'b1;
      tx_d    = TX_IDLE;
      tcnt_d  = '0;
      state_d = ST_IDLE;
    end else if (frame_fall && (state_q == ST_DISCARD)) begin
      tx_d    = TX_IDLE;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR_H: if (i_rx_valid) begin
          addr_d[ADDR_WD-1 -: 8] = iv_rx_data[7:0];
          state_d = ST_ADDR_L;
        end
        ST_ADDR_L: if (i_rx_valid) begin
          addr_d[7:0] = iv_rx_data[7:0];
          if (is_rd_q) begin
            rd_en_d = 1'b1;
            tcnt_d  = '0;
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_DATA_H;
          end
        end
        ST_DATA_H: if (i_rx_valid) begin
          wdata_d[DATA_WD-1 -: 8] = iv_rx_data[7:0];
          state_d = ST_DATA_L;
        end
        ST_DATA_L: if (i_rx_valid) begin
          wdata_d[7:0] = iv_rx_data[7:0];
          wr_d    = 1'b1;
          state_d = ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (i_rd_valid) begin
            rd_d    = iv_rd_data;
            tx_d    = iv_rd_data[DATA_WD-1 -: 8];
            load_d  = 1'b1;
            state_d = ST_RD_H;
          end else if (tcnt_q == TW'(RD_TIMEOUT - 1)) begin
            tx_d    = TX_FILL;
            load_d  = 1'b1;
            err_inc = 1'b1;
            tcnt_d  = '0;
            state_d = ST_DISCARD;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_RD_H: if (i_rx_valid) begin
          tx_d    = rd_q[7:0];
          load_d  = 1'b1;
          state_d = ST_RD_L;
        end
        ST_RD_L: if (i_rx_valid) begin
          tx_d    = TX_IDLE;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser: write, read, abort, timeout, bad
// command, resync, mid-frame reset and error counter saturation.
module tb_spi_cmd_parser;
  import spi_cmd_parser_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_active;
  logic        rx_valid;
  logic [8:0]  rx_data;
  logic        wr_en, rd_en, tx_load;
  logic [15:0] addr, wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [7:0]  tx_data, err_cnt;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_err;

  // Clock / reset
  always #5 clk = ~clk;

  spi_cmd_parser #(.ADDR_WD(16), .DATA_WD(16), .RD_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .i_frame_active(frame_active),
    .i_rx_valid(rx_valid), .iv_rx_data(rx_data),
    .o_wr_en(wr_en), .o_rd_en(rd_en), .ov_addr(addr), .ov_wr_data(wr_data),
    .i_rd_valid(rd_valid), .iv_rd_data(rd_data),
    .ov_tx_data(tx_data), .o_tx_load(tx_load), .ov_err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one byte strobe, returns at the falling edge after capture.
  task automatic send_byte(input logic [8:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_txn", {addr, wr_data}, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = '0;
    rd_valid = 1'b0; rd_data = '0; exp_err = 8'd0;
    idle(3);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_outs", {wr_en, rd_en, tx_load, tx_data, err_cnt}, 32'd0);
    check("rst_addr_data", {addr, wr_data}, 32'd0);
    reset = 1'b0; frame_active = 1'b1;
    idle(2);

    // Write 0x0055 <= 0xAB56
    exp_q.push_back({16'h0055, 16'hAB56});
    send_byte(9'h180); send_byte(9'h000); send_byte(9'h055); send_byte(9'h0AB);
    idle(1);
    send_byte(9'h056);
    check("wr_strobe", 32'(wr_en), 32'd1);
    idle(1);
    check("wr_one_cycle", 32'(wr_en), 32'd0);
    check("wr_back_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Read 0x00B4 returning 0xD836
    send_byte(9'h181); send_byte(9'h000); send_byte(9'h0B4);
    check("rd_strobe", 32'(rd_en), 32'd1);
    check("rd_addr", 32'(addr), 32'h00B4);
    idle(1);
    check("rd_one_cycle", 32'(rd_en), 32'd0);
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 16'hD836;
    @(negedge clk);
    rd_valid = 1'b0; rd_data = '0;
    check("rd_hi_load", {tx_load, tx_data}, {1'b1, 8'hD8});
    idle(1);
    check("rd_hi_hold", {tx_load, tx_data}, {1'b0, 8'hD8});
    send_byte(9'h000);
    check("rd_lo_load", {tx_load, tx_data}, {1'b1, 8'h36});
    send_byte(9'h000);
    check("rd_done", {tx_load, tx_data, 4'(dbg_state)}, {1'b0, 8'h00, 4'(ST_IDLE)});
    // Read data outside RD_WAIT is ignored
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 16'hFFFF;
    @(negedge clk);
    rd_valid = 1'b0; rd_data = '0;
    check("rd_valid_ignored", {tx_load, tx_data}, 32'd0);

    // Abort during DATA_H, then the same write succeeds
    send_byte(9'h180); send_byte(9'h001); send_byte(9'h064);
    @(negedge clk); frame_active = 1'b0;
    @(negedge clk);
    exp_err = 8'd1;
    check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_err", 32'(err_cnt), 32'(exp_err));
    frame_active = 1'b1;
    idle(1);
    exp_q.push_back({16'h0164, 16'h1357});
    send_byte(9'h180); send_byte(9'h001); send_byte(9'h064); send_byte(9'h013); send_byte(9'h057);
    check("abort_next_wr", 32'(wr_en), 32'd1);

    // Read timeout of 0x0040
    send_byte(9'h181); send_byte(9'h000); send_byte(9'h040);
    check("to_rd_strobe", {rd_en, addr}, {1'b1, 16'h0040});
    idle(14);
    check("to_not_yet", {tx_load, tx_data, err_cnt}, {1'b0, 8'h00, exp_err});
    idle(1);
    exp_err = 8'd2;
    check("to_fill", {tx_load, tx_data, err_cnt}, {1'b1, 8'hFF, exp_err});
    check("to_discard", 32'(dbg_state), 32'(ST_DISCARD));
    send_byte(9'h022);
    check("discard_ignores", 32'(dbg_state), 32'(ST_DISCARD));
    @(negedge clk); frame_active = 1'b0;
    @(negedge clk); frame_active = 1'b1;
    check("discard_end", {tx_data, err_cnt, 4'(dbg_state)}, {8'h00, exp_err, 4'(ST_IDLE)});

    // Bad command, then write interrupted by a read command
    send_byte(9'h1A5);
    exp_err = 8'd3;
    check("bad_cmd", {err_cnt, 4'(dbg_state)}, {exp_err, 4'(ST_DISCARD)});
    send_byte(9'h033);
    send_byte(9'h180); send_byte(9'h000);
    send_byte(9'h181);
    exp_err = 8'd4;
    check("resync_err", {err_cnt, 4'(dbg_state)}, {exp_err, 4'(ST_ADDR_H)});
    send_byte(9'h000); send_byte(9'h040);
    check("resync_rd", {rd_en, addr}, {1'b1, 16'h0040});
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 16'h1234;
    @(negedge clk);
    rd_valid = 1'b0; rd_data = '0;
    check("resync_rd_hi", {tx_load, tx_data}, {1'b1, 8'h12});
    send_byte(9'h000);
    check("resync_rd_lo", {tx_load, tx_data}, {1'b1, 8'h34});
    send_byte(9'h000);

    // Reset during DATA_H
    send_byte(9'h180); send_byte(9'h012); send_byte(9'h034);
    check("pre_rst_state", 32'(dbg_state), 32'(ST_DATA_H));
    #2 reset = 1'b1;
    #1;
    exp_err = 8'd0;
    check("mid_rst_outs", {wr_en, rd_en, tx_load, tx_data, err_cnt, 4'(dbg_state)}, 32'd0);
    check("mid_rst_addr_data", {addr, wr_data}, 32'd0);
    @(negedge clk); reset = 1'b0;
    send_byte(9'h056); send_byte(9'h078);
    check("post_rst_no_wr", {wr_en, 4'(dbg_state)}, {1'b0, 4'(ST_IDLE)});
    exp_q.push_back({16'h0001, 16'h1234});
    send_byte(9'h180); send_byte(9'h000); send_byte(9'h001); send_byte(9'h012); send_byte(9'h034);
    check("post_rst_wr", 32'(wr_en), 32'd1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) send_byte(9'h1A5);
    check("err_saturate", 32'(err_cnt), 32'hFF);

    idle(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter ADDR_WD, default 16, register address width (two command bytes).
REQ-002 SHALL have parameter DATA_WD, default 16, register data width (two command bytes).
REQ-003 SHALL have parameter RD_TIMEOUT, default 15, maximum clk cycles to wait for i_rd_valid.
REQ-004 SHALL have port clk  input  1  single block clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_frame_active  input  1  chip-select active from the SPI slave, already synchronised to clk.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe, a received byte is on iv_rx_data.
REQ-008 SHALL have port iv_rx_data  input  9  bit8 = first byte of frame marker; bits7:0 = byte.
REQ-009 SHALL have port o_wr_en  output  1  one-cycle register write strobe.
REQ-010 SHALL have port o_rd_en  output  1  one-cycle register read strobe.
REQ-011 SHALL have port ov_addr  output  ADDR_WD  register address, valid with o_wr_en/o_rd_en.
REQ-012 SHALL have port ov_wr_data  output  DATA_WD  write data, valid with o_wr_en.
REQ-013 SHALL have port i_rd_valid  input  1  read data valid strobe from the register bank.
REQ-014 SHALL have port iv_rd_data  input  DATA_WD  read data, sampled when i_rd_valid=1.
REQ-015 SHALL have port ov_tx_data  output  8  next byte for the SPI slave MISO shifter.
REQ-016 SHALL have port o_tx_load  output  1  one-cycle strobe, ov_tx_data is updated.
REQ-017 SHALL have port ov_err_cnt  output  8  saturating count of aborted/invalid frames.

Function
REQ-018 SHALL use states IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, RD_WAIT, RD_H, RD_L, DISCARD.
REQ-019 SHALL, in any state, on i_rx_valid with iv_rx_data[8]=1, treat the byte as a new command (resynchronise).
REQ-020 SHALL decode command byte 0x80 as write, 0x81 as read, go to ADDR_H; any other command byte -> DISCARD, ov_err_cnt+1.
REQ-021 SHALL ignore i_rx_valid with bit8=0 while in IDLE or DISCARD.
REQ-022 SHALL load ov_addr[15:8] in ADDR_H and ov_addr[7:0] in ADDR_L, one byte per i_rx_valid.
REQ-023 SHALL, for write, collect data_hi in DATA_H, data_lo in DATA_L, then assert o_wr_en for exactly one cycle, the cycle after the data_lo strobe, with ov_addr/ov_wr_data stable, then return to IDLE.
REQ-024 SHALL, for read, assert o_rd_en one cycle after the addr_lo strobe and enter RD_WAIT.
REQ-025 SHALL, in RD_WAIT, capture iv_rd_data on i_rd_valid, drive ov_tx_data=rd[15:8] with o_tx_load the next cycle, enter RD_H.
REQ-026 SHALL, in RD_H, on the next i_rx_valid (data_hi slot, dummy byte) drive ov_tx_data=rd[7:0] with o_tx_load next cycle, enter RD_L; on the following i_rx_valid return to IDLE.
REQ-027 SHALL, if i_rd_valid is not seen within RD_TIMEOUT cycles in RD_WAIT, load ov_tx_data=0xFF, increment ov_err_cnt, enter DISCARD.
REQ-028 SHALL, on i_frame_active falling in any state other than IDLE/DISCARD before the frame completes, abort to IDLE without o_wr_en and increment ov_err_cnt.
REQ-029 SHALL hold ov_tx_data at 0x00 outside read frames; o_tx_load only pulses per REQ-025/026/027.
REQ-030 SHALL saturate ov_err_cnt at 0xFF (no wrap).
REQ-031 SHALL give resynchronisation (REQ-019) priority over timeout and abort in the same cycle; a pending write not yet strobed is dropped and counted.
REQ-032 SHALL ignore i_rd_valid outside RD_WAIT.

Reset
REQ-033 SHALL, on reset, asynchronously force state IDLE, o_wr_en=0, o_rd_en=0, o_tx_load=0, ov_addr=0, ov_wr_data=0, ov_tx_data=0x00, ov_err_cnt=0, timeout counter=0.
REQ-034 SHALL, when reset asserts mid-frame, discard the partial frame; the first command after release is parsed normally.

Structure
REQ-035 SHALL place command codes (0x80, 0x81), timeout fill byte 0xFF and state encodings in the shared SPI package.
REQ-036 SHALL be one module; no sub-module is required (timeout counter inline).

Verification
REQ-037 SHALL cover write: bytes 0x180,0x00,0x55,0xAB,0x56 -> one o_wr_en, ov_addr=0x0055, ov_wr_data=0xAB56.
REQ-038 SHALL cover read: 0x181,0x00,0xB4,dummy,dummy, i_rd_valid with 0xD836 two cycles after o_rd_en -> o_rd_en with ov_addr=0x00B4, tx loads 0xD8 then 0x36.
REQ-039 SHALL cover abort: 0x180,0x01,0x64 then i_frame_active=0 -> no o_wr_en, ov_err_cnt=1, next write to 0x0164 succeeds.
REQ-040 SHALL cover timeout: read of 0x0040 with i_rd_valid never asserted -> after 15 cycles ov_tx_data=0xFF, ov_err_cnt+1.
REQ-041 SHALL cover bad command 0x1A5 and mid-frame resync (0x180,0x00 then 0x181,0x00,0x40) -> discard counted, read of 0x0040 issued.
REQ-042 SHALL cover reset asserted during DATA_H -> all outputs reset values, no o_wr_en.
